// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic {
    M0_CORE = 1'b0,
    M1_DBG  = 1'b1
  } master_id_e;

  // After this many m0 wins while m1 waits, m1 wins the next contention.
  localparam logic [3:0] STARVE_MAX = 4'd15;

  localparam int unsigned CMD_ADDR_W = 32;
  localparam int unsigned CMD_DATA_W = 32;

  // Memory command bundle at the default port widths.
  typedef struct packed {
    logic [CMD_ADDR_W-1:0]   addr;
    logic                    we;
    logic [CMD_DATA_W/8-1:0] be;
    logic [CMD_DATA_W-1:0]   wdata;
  } mem_cmd_t;

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational master selection from the two requests plus policy state.
// Build option: DMEM_ARB_RR_EN selects round-robin; otherwise fixed priority
// m0 > m1 with an anti-starvation override.
module dmem_arb_pick
  import dmem_arb_pkg::*;
(
  input  logic       req0_i,
  input  logic       req1_i,
`ifdef DMEM_ARB_RR_EN
  input  master_id_e last_i,
`else
  input  logic [3:0] starve_cnt_i,
`endif
  output master_id_e sel_o
);

  // Lone requester always wins; contention is resolved by the policy.
  always_comb begin
    sel_o = M0_CORE;
    if (req0_i && req1_i) begin
`ifdef DMEM_ARB_RR_EN
      sel_o = (last_i == M0_CORE) ? M1_DBG : M0_CORE;
`else
      sel_o = (starve_cnt_i >= STARVE_MAX) ? M1_DBG : M0_CORE;
`endif
    end else if (req1_i) begin
      sel_o = M1_DBG;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master data-memory arbiter (core port m0, debug port m1) with a
// one-deep response pipeline routing read data back to the owner.
// Build option: DMEM_ARB_RR_EN enables round-robin arbitration.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                m0_req_i,
  output logic                m0_gnt_o,
  input  logic [ADDR_W-1:0]   m0_addr_i,
  input  logic                m0_we_i,
  input  logic [DATA_W/8-1:0] m0_be_i,
  input  logic [DATA_W-1:0]   m0_wdata_i,
  output logic                m0_rvalid_o,
  output logic [DATA_W-1:0]   m0_rdata_o,
  input  logic                m1_req_i,
  output logic                m1_gnt_o,
  input  logic [ADDR_W-1:0]   m1_addr_i,
  input  logic                m1_we_i,
  input  logic [DATA_W/8-1:0] m1_be_i,
  input  logic [DATA_W-1:0]   m1_wdata_i,
  output logic                m1_rvalid_o,
  output logic [DATA_W-1:0]   m1_rdata_o,
  output logic                mem_req_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic                mem_we_o,
  output logic [DATA_W/8-1:0] mem_be_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  input  logic                mem_gnt_i,
  input  logic [DATA_W-1:0]   mem_rdata_i
);

  master_id_e sel;
  logic       xfer;
  logic       resp_vld_q, resp_vld_d;
  master_id_e resp_owner_q, resp_owner_d;
`ifdef DMEM_ARB_RR_EN
  master_id_e last_q, last_d;
`else
  logic [3:0] starve_cnt_q, starve_cnt_d;
`endif

  dmem_arb_pick u_pick (
    .req0_i       (m0_req_i),
    .req1_i       (m1_req_i),
`ifdef DMEM_ARB_RR_EN
    .last_i       (last_q),
`else
    .starve_cnt_i (starve_cnt_q),
`endif
    .sel_o        (sel)
  );

  assign mem_req_o = m0_req_i | m1_req_i;
  assign xfer      = mem_req_o & mem_gnt_i;

  // Grants are gated by reset so they drop the moment reset asserts.
  assign m0_gnt_o = rst_n & xfer & (sel == M0_CORE);
  assign m1_gnt_o = rst_n & xfer & (sel == M1_DBG);

  // Command mux: forward the selected master's fields to memory.
  always_comb begin
    mem_addr_o  = m0_addr_i;
    mem_we_o    = m0_we_i;
    mem_be_o    = m0_be_i;
    mem_wdata_o = m0_wdata_i;
    if (sel == M1_DBG) begin
      mem_addr_o  = m1_addr_i;
      mem_we_o    = m1_we_i;
      mem_be_o    = m1_be_i;
      mem_wdata_o = m1_wdata_i;
    end
  end

  // Next-state for the response pipeline and the arbitration policy.
  always_comb begin
    resp_vld_d   = xfer;
    resp_owner_d = xfer ? sel : resp_owner_q;
`ifdef DMEM_ARB_RR_EN
    last_d = xfer ? sel : last_q;
`else
    starve_cnt_d = starve_cnt_q;
    if (xfer) begin
      if (sel == M1_DBG) begin
        starve_cnt_d = '0;
      end else if (m1_req_i && (starve_cnt_q < STARVE_MAX)) begin
        starve_cnt_d = starve_cnt_q + 4'd1;
      end
    end
`endif
  end

  // State registers; last owner resets to m1 so m0 wins the first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_vld_q   <= 1'b0;
      resp_owner_q <= M0_CORE;
`ifdef DMEM_ARB_RR_EN
      last_q       <= M1_DBG;
`else
      starve_cnt_q <= '0;
`endif
    end else begin
      resp_vld_q   <= resp_vld_d;
      resp_owner_q <= resp_owner_d;
`ifdef DMEM_ARB_RR_EN
      last_q       <= last_d;
`else
      starve_cnt_q <= starve_cnt_d;
`endif
    end
  end

  // Response routing: memory data goes only to the owner, zero elsewhere.
  always_comb begin
    m0_rvalid_o = resp_vld_q & (resp_owner_q == M0_CORE);
    m1_rvalid_o = resp_vld_q & (resp_owner_q == M1_DBG);
    m0_rdata_o  = m0_rvalid_o ? mem_rdata_i : '0;
    m1_rdata_o  = m1_rvalid_o ? mem_rdata_i : '0;
  end

endmodule
